// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a circular receive FIFO, all on one clock.
//
// Build option: define UART_RX_PARITY_EN to expect and check one parity bit after the data
// bits (even or odd per ODD_PARITY). Without it there is no parity bit and parity_err is 0.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   rd_en      pop request, ignored while empty
//   clear_err  clears the sticky error flags (a same-cycle new error wins)
//   rd_data    popped word, registered (valid with rd_valid, one cycle after rd_en)
//   rd_valid   one-cycle pulse marking rd_data
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      current occupancy
//   overflow   sticky: a received frame was dropped because the FIFO was full
//   frame_err  sticky: stop bit sampled low (frame discarded)
//   parity_err sticky: parity mismatch (frame still stored)
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV    = 13,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned OsW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [OsW-1:0]  OsHalf   = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
  localparam logic [PtrW:0]   DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------------------
  // Receive FSM with tick and oversample counters
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [DivW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [OsW-1:0]      os_cnt_q, os_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                push_q, push_d;
  logic                tick, sample;
  logic                frame_set, parity_set;

  assign tick = (clk_cnt_q == DivLast);
  // START samples mid start bit; every later bit is one full bit period on.
  assign sample = tick && (os_cnt_q == ((state_q == StStart) ? OsHalf : OsLast));

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = tick ? '0 : clk_cnt_q + DivW'(1);
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;

    if (state_q != StIdle && tick) begin
      os_cnt_d = sample ? '0 : os_cnt_q + OsW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d   = StStart;
          clk_cnt_d = '0;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        // Line back high at mid start bit: a glitch, quietly ignore it.
        if (sample) state_d = rx_sync ? StIdle : StData;
      end
      StData: begin
        if (sample) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (sample) begin
          state_d    = StStop;
          parity_set = (rx_sync != ((^shift_q) ^ (ODD_PARITY != 0)));
        end
      end
`endif
      StStop: begin
        // Leave mid stop bit so the next start edge is never missed.
        if (sample) begin
          state_d = StIdle;
          if (rx_sync) push_d    = 1'b1;
          else         frame_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. shift_q holds the completed frame during the push cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 pop, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign count   = count_q;
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data  <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (push_ok && !pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error takes priority over clear_err.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_q && full && !pop) overflow <= 1'b1;
      else if (clear_err)         overflow <= 1'b0;
      if (frame_set)              frame_err <= 1'b1;
      else if (clear_err)         frame_err <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)           parity_err <= 1'b0;
    else if (parity_set) parity_err <= 1'b1;
    else if (clear_err)  parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a default-size instance (a) and a 4-deep instance (b).
module tb_uart_rx_fifo;

  localparam int CLK_DIV = 13;
  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int BIT     = CLK_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // Negedges after the start-bit negedge until the one just before the push-cycle edge:
  // 2 sync flops + 1 detect edge, then the stop sample, then 1 more clock to the push.
  localparam int PUSH_WAIT = 3 + (OS / 2 + (DB + 1 + P) * OS) * CLK_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1, rd_en_a = 1'b0, clear_a = 1'b0;
  logic       rx_b = 1'b1, rd_en_b = 1'b0, clear_b = 1'b0;
  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, empty_a, full_a, overflow_a, frame_err_a, parity_err_a;
  logic       rd_valid_b, empty_b, full_b, overflow_b, frame_err_b, parity_err_b;
  logic [9:0] count_a;
  logic [2:0] count_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(DB), .FIFO_DEPTH(512),
                 .ODD_PARITY(0)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .rd_en(rd_en_a), .clear_err(clear_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .full(full_a),
    .count(count_a), .overflow(overflow_a), .frame_err(frame_err_a),
    .parity_err(parity_err_a)
  );

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(DB), .FIFO_DEPTH(4),
                 .ODD_PARITY(0)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .rd_en(rd_en_b), .clear_err(clear_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
    .count(count_b), .overflow(overflow_b), .frame_err(frame_err_b),
    .parity_err(parity_err_b)
  );

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Full frame on instance sel; parity bit only sent when parity is compiled in.
  task automatic send_frame(input bit sel, input logic [7:0] data, input logic par,
                            input logic stop);
    @(negedge clk);
    drive_rx(sel, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      drive_rx(sel, data[i]);
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    drive_rx(sel, par);
    repeat (BIT) @(negedge clk);
`else
    if (par) begin end
`endif
    drive_rx(sel, stop);
    repeat (BIT) @(negedge clk);
    drive_rx(sel, 1'b1);
    repeat (16) @(negedge clk);
  endtask

  task automatic pop(input bit sel, output logic [7:0] d, output logic v);
    @(negedge clk);
    if (sel) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
    d = sel ? rd_data_b : rd_data_a;
    v = sel ? rd_valid_b : rd_valid_a;
  endtask

  task automatic test_reset;
    logic [24:0] exp_a;
    logic [17:0] exp_b;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_a = {8'h00, 1'b0, 1'b1, 1'b0, 10'd0, 3'b000};
    exp_b = {8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'b000};
    vectors++;
    if ({rd_data_a, rd_valid_a, empty_a, full_a, count_a, overflow_a, frame_err_a,
         parity_err_a} !== exp_a) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected %h", {rd_data_a, rd_valid_a, empty_a, full_a,
               count_a, overflow_a, frame_err_a, parity_err_a}, exp_a);
    end
    vectors++;
    if ({rd_data_b, rd_valid_b, empty_b, full_b, count_b, overflow_b, frame_err_b,
         parity_err_b} !== exp_b) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected %h", {rd_data_b, rd_valid_b, empty_b, full_b,
               count_b, overflow_b, frame_err_b, parity_err_b}, exp_b);
    end
  endtask

  task automatic test_single;
    logic [7:0] d;
    logic       v;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    vectors++;
    if (count_a !== 10'd1) begin
      miscompares++; $display("FAIL single_count: got %0d expected 1", count_a);
    end
    vectors++;
    if (empty_a !== 1'b0) begin
      miscompares++; $display("FAIL single_not_empty: got %b expected 0", empty_a);
    end
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'hA5) begin
      miscompares++; $display("FAIL single_pop: got v=%b d=%h expected v=1 d=a5", v, d);
    end
    @(negedge clk);
    vectors++;
    if (rd_valid_a !== 1'b0 || empty_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_after: got valid=%b empty=%b expected 0 1", rd_valid_a, empty_a);
    end
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b0 || count_a !== 10'd0) begin
      miscompares++;
      $display("FAIL pop_empty: got v=%b count=%0d expected 0 0", v, count_a);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    logic       v;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT * 2) @(negedge clk);
    vectors++;
    if ({count_a, overflow_a, frame_err_a, parity_err_a} !== 13'd0) begin
      miscompares++;
      $display("FAIL glitch: got count=%0d flags=%b expected 0 000", count_a,
               {overflow_a, frame_err_a, parity_err_a});
    end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h5A) begin
      miscompares++; $display("FAIL glitch_next: got v=%b d=%h expected v=1 d=5a", v, d);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] d;
    logic       v;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    vectors++;
    if (frame_err_a !== 1'b1 || count_a !== 10'd0) begin
      miscompares++;
      $display("FAIL frame_err: got flag=%b count=%0d expected 1 0", frame_err_a, count_a);
    end
    @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    vectors++;
    if (frame_err_a !== 1'b0) begin
      miscompares++; $display("FAIL frame_clear: got %b expected 0", frame_err_a);
    end
    send_frame(1'b0, 8'h55, 1'b0, 1'b1);
    vectors++;
    if (count_a !== 10'd1 || frame_err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_recover: got count=%0d flag=%b expected 1 0", count_a, frame_err_a);
    end
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h55) begin
      miscompares++; $display("FAIL frame_recover_pop: got v=%b d=%h expected 1 55", v, d);
    end
  endtask

  task automatic test_parity;
    logic [7:0] d;
    logic       v;
`ifdef UART_RX_PARITY_EN
    send_frame(1'b0, 8'h07, 1'b1, 1'b1);
    vectors++;
    if (parity_err_a !== 1'b0 || count_a !== 10'd1) begin
      miscompares++;
      $display("FAIL parity_good: got flag=%b count=%0d expected 0 1", parity_err_a, count_a);
    end
    send_frame(1'b0, 8'h07, 1'b0, 1'b1);
    vectors++;
    if (parity_err_a !== 1'b1 || count_a !== 10'd2) begin
      miscompares++;
      $display("FAIL parity_bad: got flag=%b count=%0d expected 1 2", parity_err_a, count_a);
    end
    pop(1'b0, d, v);
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'h07) begin
      miscompares++; $display("FAIL parity_bad_pop: got v=%b d=%h expected 1 07", v, d);
    end
    @(negedge clk);
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
`else
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
    vectors++;
    if (parity_err_a !== 1'b0 || count_a !== 10'd1) begin
      miscompares++;
      $display("FAIL no_parity: got flag=%b count=%0d expected 0 1", parity_err_a, count_a);
    end
    pop(1'b0, d, v);
    vectors++;
    if (v !== 1'b1 || d !== 8'hC3) begin
      miscompares++; $display("FAIL no_parity_pop: got v=%b d=%h expected 1 c3", v, d);
    end
`endif
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (BIT * 4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_a = 1'b1;
    repeat (BIT * 12) @(negedge clk);
    vectors++;
    if (count_a !== 10'd0 || empty_a !== 1'b1 || frame_err_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got count=%0d empty=%b ferr=%b expected 0 1 0",
               count_a, empty_a, frame_err_a);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic       v;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(1'b1, d, ^d, 1'b1);
    end
    vectors++;
    if (full_b !== 1'b1 || count_b !== 3'd4 || overflow_b !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got full=%b count=%0d ovf=%b expected 1 4 1", full_b, count_b,
               overflow_b);
    end
    for (int i = 1; i <= 4; i++) begin
      pop(1'b1, d, v);
      vectors++;
      if (v !== 1'b1 || d !== 8'(i)) begin
        miscompares++; $display("FAIL overflow_pop%0d: got v=%b d=%h expected 1 %h", i, v, d,
                                8'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (empty_b !== 1'b1 || count_b !== 3'd0) begin
      miscompares++;
      $display("FAIL overflow_drain: got empty=%b count=%0d expected 1 0", empty_b, count_b);
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] d;
    logic       v;
    logic [7:0] fill [4];
    logic [7:0] drain [4];
    fill  = '{8'h06, 8'h07, 8'h08, 8'h0B};
    drain = '{8'h07, 8'h08, 8'h0B, 8'h09};
    @(negedge clk);
    clear_b = 1'b1;
    @(negedge clk);
    clear_b = 1'b0;
    vectors++;
    if (overflow_b !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clear: got %b expected 0", overflow_b);
    end
    for (int i = 0; i < 4; i++) send_frame(1'b1, fill[i], ^fill[i], 1'b1);
    vectors++;
    if (full_b !== 1'b1) begin
      miscompares++; $display("FAIL refill_full: got %b expected 1", full_b);
    end
    fork
      send_frame(1'b1, 8'h09, ^8'h09, 1'b1);
      begin
        @(negedge clk);
        repeat (PUSH_WAIT) @(negedge clk);
        rd_en_b = 1'b1;
        @(negedge clk);
        rd_en_b = 1'b0;
        vectors++;
        if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h06 || count_b !== 3'd4 ||
            overflow_b !== 1'b0) begin
          miscompares++;
          $display("FAIL full_pop_push: got v=%b d=%h count=%0d ovf=%b expected 1 06 4 0",
                   rd_valid_b, rd_data_b, count_b, overflow_b);
        end
      end
    join
    vectors++;
    if (count_b !== 3'd4 || overflow_b !== 1'b0) begin
      miscompares++;
      $display("FAIL full_pop_after: got count=%0d ovf=%b expected 4 0", count_b, overflow_b);
    end
    for (int i = 0; i < 4; i++) begin
      pop(1'b1, d, v);
      vectors++;
      if (v !== 1'b1 || d !== drain[i]) begin
        miscompares++;
        $display("FAIL full_pop_drain%0d: got v=%b d=%h expected 1 %h", i, v, d, drain[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_parity();
    test_reset_mid_frame();
    test_overflow();
    test_full_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
